// File: rtl/retire_trace_checker.sv
// retire_trace_checker: queues expected register/flag results, compares each
// retiring write under a mask, counts pass/fail, reports mismatches and
// flags a stalled core through an idle-cycle watchdog.
module retire_trace_checker #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic              exp_kind,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] exp_mask,
  input  logic              exp_last,
  input  logic              ret_valid,
  input  logic              ret_kind,
  input  logic [ADDR_W-1:0] ret_addr,
  input  logic [DATA_W-1:0] ret_data,
  input  logic              start,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              timeout_err,
  output logic              unexpected,
  output logic              mismatch_valid,
  output logic [ADDR_W-1:0] mismatch_addr,
  output logic [DATA_W-1:0] mismatch_got,
  output logic [DATA_W-1:0] mismatch_exp
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic              kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
    logic              last;
  } entry_t;

  entry_t            mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              timeout_err_q, timeout_err_d;
  logic              unexpected_q, unexpected_d;
  logic              mm_valid_q, mm_valid_d;
  logic [ADDR_W-1:0] mm_addr_q, mm_addr_d;
  logic [DATA_W-1:0] mm_got_q, mm_got_d, mm_exp_q, mm_exp_d;

  logic   full, empty, push, ret_pass, pass_inc, fail_inc, run_clear;
  entry_t head, entry_in;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign exp_ready = !full;
  assign push      = exp_valid && !full && !flush;
  assign head      = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign entry_in  = '{kind: exp_kind, addr: exp_addr, data: exp_data,
                       mask: exp_mask, last: exp_last};

  // Flag retires carry no destination register, so the address is not compared.
  assign ret_pass = (ret_kind == head.kind) &&
                    (head.kind || (ret_addr == head.addr)) &&
                    ((ret_data & head.mask) == (head.data & head.mask));

  // Entry storage; written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= entry_in;
  end

  // Next-state, pointer, counter and report logic.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pass_cnt_d    = pass_cnt_q;
    fail_cnt_d    = fail_cnt_q;
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
    unexpected_d  = unexpected_q;
    mm_valid_d    = 1'b0;
    mm_addr_d     = mm_addr_q;
    mm_got_d      = mm_got_q;
    mm_exp_d      = mm_exp_q;
    pass_inc      = 1'b0;
    fail_inc      = 1'b0;
    run_clear     = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          run_clear = 1'b1;
        end
      end
      RUN: begin
        // A flush swallows any retire in the same cycle: counters untouched.
        if (flush) begin
          wd_d = '0;
        end else if (ret_valid) begin
          wd_d = '0;
          if (!empty) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            if (ret_pass) begin
              pass_inc = 1'b1;
            end else begin
              fail_inc   = 1'b1;
              mm_valid_d = 1'b1;
              mm_addr_d  = head.addr;
              mm_got_d   = ret_data;
              mm_exp_d   = head.data;
            end
            if (head.last) state_d = DONE;
          end else begin
            fail_inc     = 1'b1;
            unexpected_d = 1'b1;
          end
        end else if (empty) begin
          wd_d = '0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          wd_d          = '0;
          timeout_err_d = 1'b1;
          state_d       = DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (run_clear) begin
      pass_cnt_d    = '0;
      fail_cnt_d    = '0;
      wd_d          = '0;
      timeout_err_d = 1'b0;
      unexpected_d  = 1'b0;
    end
    if (pass_inc && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
    if (fail_inc && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + CNT_W'(1);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pass_cnt_q    <= '0;
      fail_cnt_q    <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
      unexpected_q  <= 1'b0;
      mm_valid_q    <= 1'b0;
      mm_addr_q     <= '0;
      mm_got_q      <= '0;
      mm_exp_q      <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pass_cnt_q    <= pass_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
      unexpected_q  <= unexpected_d;
      mm_valid_q    <= mm_valid_d;
      mm_addr_q     <= mm_addr_d;
      mm_got_q      <= mm_got_d;
      mm_exp_q      <= mm_exp_d;
    end
  end

  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign timeout_err    = timeout_err_q;
  assign unexpected     = unexpected_q;
  assign mismatch_valid = mm_valid_q;
  assign mismatch_addr  = mm_addr_q;
  assign mismatch_got   = mm_got_q;
  assign mismatch_exp   = mm_exp_q;
endmodule

// File: doc/retire_trace_checker.md
# retire_trace_checker

Parametrised, self-checking retirement-trace checker that sits beside the ARM core's register-file write port and flag register. It generalises the per-test register and flag checks into hardware: expected results are queued in a FIFO, each retiring write is compared under a mask, pass/fail counts accumulate, mismatches are reported, and a watchdog flags a stalled core. It is used in simulation and in on-FPGA bring-up.

## Interface
- DATA_W, 32: retire and expected data width.
- ADDR_W, 4: register address width (16 registers).
- DEPTH, 16: expected-entry FIFO depth; power of two, ≥2.
- TIMEOUT, 64: idle-cycle limit for the watchdog; ≥2.
- CNT_W, 16: pass/fail counter width.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- exp_valid  in  1  expected entry offered.
- exp_ready  out  1  `= !full`; push occurs when exp_valid && exp_ready.
- exp_kind  in  1  0 = register write, 1 = flags (NZCV in data[3:0]).
- exp_addr  in  ADDR_W  expected destination register (ignored when kind = 1).
- exp_data  in  DATA_W  expected value.
- exp_mask  in  DATA_W  compare mask; a 1 means the bit is checked.
- exp_last  in  1  marks the final entry of a run.
- ret_valid  in  1  one retirement event this cycle.
- ret_kind, ret_addr, ret_data  in  1/ADDR_W/DATA_W  retirement event fields.
- start  in  1  begin a run.
- flush  in  1  empty the FIFO.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- pass_cnt, fail_cnt  out  CNT_W  saturating result counters.
- timeout_err  out  1  sticky; set on watchdog expiry.
- unexpected  out  1  sticky; set on a retire while the FIFO is empty.
- mismatch_valid  out  1  one-cycle pulse on a failed compare.
- mismatch_addr, mismatch_got, mismatch_exp  out  ADDR_W/DATA_W/DATA_W  details of the last failure; held until the next failure.

## Operation
- **FIFO:** DEPTH entries of {kind, addr, data, mask, last}.
  - Pointers are ADDR-of-DEPTH bits plus one wrap bit.
  - full/empty are derived from the pointers.
  - There is no bypass: an entry pushed in cycle N is poppable from N+1.
  - Pushes are accepted in every state.
- **flush:** has priority over push and pop in the same cycle. It empties the FIFO and leaves counters and state unchanged.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN on start. Clears pass_cnt, fail_cnt, timeout_err, unexpected and the watchdog; the FIFO is kept.
  - RUN, on ret_valid with the FIFO non-empty: pop the head entry. Pass iff all of the following hold:
    - ret_kind == head.kind;
    - (kind == 1 or ret_addr == head.addr);
    - (ret_data & mask) == (head.data & mask).
  - On pass: pass_cnt += 1. On fail: fail_cnt += 1, pulse mismatch_valid, and latch head.addr, ret_data and head.data.
  - If the popped entry has last = 1: RUN → DONE.
  - RUN, on ret_valid with the FIFO empty: fail_cnt += 1 and set unexpected. No pop and no mismatch pulse.
  - RUN, watchdog: counts cycles with the FIFO non-empty and ret_valid = 0. It is cleared by any ret_valid or when the FIFO is empty. When it reaches TIMEOUT: set timeout_err and go RUN → DONE.
  - DONE: ret_valid is ignored. start → RUN with the same clears as IDLE → RUN.
  - start in RUN is ignored.
- **Counters:** saturate at 2^CNT_W−1 and do not wrap.

## Timing
- **Reset (asynchronous, rst = 0):**
  - state = IDLE; FIFO empty, so exp_ready = 1.
  - All counters, sticky flags, mismatch_* outputs and the watchdog are 0.
  - busy = 0 and done = 0.
- **Compare latency:** 1 cycle. For ret_valid sampled at edge N, the counter, mismatch and done updates are visible after edge N. Back-to-back retires are supported, one per cycle.
- **Watchdog:** timeout_err asserts on the edge that ends the TIMEOUT-th consecutive idle cycle. done asserts on the same edge.
- **Reset mid-run:** everything returns to the reset values immediately. There is no partial counter retention.
- **Push to a full FIFO:** exp_ready = 0, nothing is written, and the pointers do not move. A simultaneous pop on the same cycle does not raise exp_ready combinationally.

## Test plan
1. **Matching sequence.** Preload 3 entries: {0, R1, 5, FFFFFFFF}, {0, R2, 3, FFFFFFFF}, {0, R3, 8, FFFFFFFF, last}. Pulse start, then retire R1=5, R2=3, R3=8 on consecutive cycles. Required: pass_cnt = 3, fail_cnt = 0, done = 1 one cycle after the third retire.
2. **Masked flags plus a mismatch.** Entries {1, –, 0x8, 0xF} and {0, R4, 3, FFFFFFFF, last}. Retire flags 0xFFFFFFF8, then R4 = 7. Required: pass_cnt = 1, fail_cnt = 1, a single mismatch_valid pulse, mismatch_addr = 4, mismatch_got = 7, mismatch_exp = 3.
3. **Unexpected retire.** Start with the FIFO empty, then retire R5 = 1. Required: fail_cnt = 1, unexpected = 1, no mismatch pulse, state stays RUN.
4. **Watchdog.** TIMEOUT = 4; one entry queued, start, no retires. Required: timeout_err = 1 and done = 1 exactly 4 cycles after RUN is entered. A following start clears timeout_err.
5. **FIFO boundaries.**
   - Push DEPTH entries: exp_ready = 0 after the DEPTH-th push, and a DEPTH+1-th exp_valid is dropped.
   - flush together with exp_valid: FIFO empty and exp_ready = 1.
   - Fill, drain and wrap twice: all entries compare in order.
6. **Reset mid-run.** Drive rst low after 2 of 4 retires. Required: counters = 0, state IDLE and FIFO empty immediately, without waiting for a clock edge.
